uart_boot_ctrl: RTL and testbench

UART_BOOT_CTRL -- requirements
Module: uart_boot_ctrl

---
 rtl/uart_boot_pkg.sv | 31 +++
 rtl/uart_boot_ctrl_if.sv | 26 ++
 rtl/uart_boot_ctrl.sv | 169 ++++++++++++++++
 tb/tb_uart_boot_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_boot_pkg.sv
// rtl/uart_boot_pkg.sv - state encoding, sync byte and error codes for the UART boot loader
package uart_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } boot_state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_LENGTH  = 2'd2;
    localparam logic [1:0] ERR_CSUM    = 2'd3;

    function automatic logic is_busy(input boot_state_t s);
        return s inside {ST_SYNC, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM};
    endfunction

    // SYNC waits forever for the sync byte; only the frame body is watchdogged.
    function automatic logic is_timed(input boot_state_t s);
        return s inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM};
    endfunction

endpackage

// File: rtl/uart_boot_ctrl_if.sv
// rtl/uart_boot_ctrl_if.sv - UART byte input, boot status and RAM write port bundle
interface uart_boot_ctrl_if #(
    parameter int ADDR_LEN = 14,
    parameter int XLEN     = 32
);
    logic                  boot_req_b;
    logic                  uart_rx_valid;
    logic [7:0]            uart_rx_data;
    logic                  cpu_hold;
    logic                  boot_busy;
    logic [1:0]            boot_err;
    logic                  ram_wr_en;
    logic [ADDR_LEN-1:0]   ram_addr;
    logic [XLEN-1:0]       ram_wr_data;
    logic [XLEN/8-1:0]     ram_we;

    modport master (
        output boot_req_b, uart_rx_valid, uart_rx_data,
        input  cpu_hold, boot_busy, boot_err, ram_wr_en, ram_addr, ram_wr_data, ram_we
    );

    modport slave (
        input  boot_req_b, uart_rx_valid, uart_rx_data,
        output cpu_hold, boot_busy, boot_err, ram_wr_en, ram_addr, ram_wr_data, ram_we
    );
endinterface

// File: rtl/uart_boot_ctrl.sv
// rtl/uart_boot_ctrl.sv - UART boot loader FSM; UART_BOOT_CHECKSUM_EN adds the XOR checksum stage
module uart_boot_ctrl #(
    parameter int ADDR_LEN    = 14,
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic            clk,
    input  logic            rstb,
    uart_boot_ctrl_if.slave bus
);
    import uart_boot_pkg::*;

    localparam int          BYTES     = XLEN / 8;
    localparam int          BIDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int          TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_LEN;

`ifdef UART_BOOT_CHECKSUM_EN
    localparam boot_state_t ST_AFTER_DATA = ST_CSUM;
`else
    localparam boot_state_t ST_AFTER_DATA = ST_DONE;
`endif

    boot_state_t         state_q, state_d;
    logic [1:0]          err_q, err_d;
    logic                cpu_hold_q, busy_q, wr_en_q;
    logic [ADDR_LEN-1:0] addr_q;
    logic [XLEN-1:0]     wr_data_q, word_q, word_d;
    logic [BYTES-1:0]    we_q;
    logic [7:0]          len_lo_q;
    logic [15:0]         len_q, len_word, word_cnt_q;
    logic [BIDX_W-1:0]   byte_idx_q;
    logic [TW-1:0]       idle_cnt_q;
`ifdef UART_BOOT_CHECKSUM_EN
    logic [7:0]          csum_q;
`endif

    logic                boot_req_b, rx_valid;
    logic [7:0]          rx_data;
    logic                last_byte, wr_fire, timed, timeout, sync_entry;

    assign boot_req_b = bus.boot_req_b;
    assign rx_valid   = bus.uart_rx_valid;
    assign rx_data    = bus.uart_rx_data;

    assign bus.cpu_hold    = cpu_hold_q;
    assign bus.boot_busy   = busy_q;
    assign bus.boot_err    = err_q;
    assign bus.ram_wr_en   = wr_en_q;
    assign bus.ram_addr    = addr_q;
    assign bus.ram_wr_data = wr_data_q;
    assign bus.ram_we      = we_q;

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        wr_fire    = 1'b0;
        len_word   = {rx_data, len_lo_q};
        last_byte  = (byte_idx_q == BIDX_W'(BYTES - 1));
        word_d     = word_q;
        word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
        timed      = is_timed(state_q);
        timeout    = timed && !rx_valid && (idle_cnt_q == TW'(TIMEOUT_CYC - 1));

        case (state_q)
            ST_IDLE:   state_d = boot_req_b ? ST_DONE : ST_SYNC;
            ST_SYNC:   if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_LEN_LO;
            ST_LEN_LO: if (rx_valid) state_d = ST_LEN_HI;
            ST_LEN_HI: begin
                if (rx_valid) begin
                    if (32'(len_word) > MAX_WORDS) begin
                        state_d = ST_ERR;
                        err_d   = ERR_LENGTH;
                    end else if (len_word == 16'd0) begin
                        state_d = ST_AFTER_DATA;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid && last_byte) begin
                    wr_fire = 1'b1;
                    if (word_cnt_q + 16'd1 == len_q) state_d = ST_AFTER_DATA;
                end
            end
`ifdef UART_BOOT_CHECKSUM_EN
            ST_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = ERR_CSUM;
                    end
                end
            end
`endif
            ST_DONE,
            ST_ERR:    if (!boot_req_b) state_d = ST_SYNC;
            default:   state_d = ST_IDLE;
        endcase

        // Only idle cycles can time out, so a byte in the expiry cycle always wins.
        if (timeout) begin
            state_d = ST_ERR;
            err_d   = ERR_TIMEOUT;
        end

        sync_entry = (state_d == ST_SYNC) && (state_q != ST_SYNC);
        if (sync_entry) err_d = ERR_NONE;
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q    <= ST_IDLE;
            err_q      <= ERR_NONE;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            we_q       <= '0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            word_q     <= '0;
            len_lo_q   <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            idle_cnt_q <= '0;
`ifdef UART_BOOT_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            cpu_hold_q <= (state_d != ST_DONE);
            busy_q     <= is_busy(state_d);
            wr_en_q    <= wr_fire;
            we_q       <= wr_fire ? '1 : '0;
            idle_cnt_q <= (rx_valid || !timed) ? '0 : idle_cnt_q + 1'b1;

            if (state_q == ST_LEN_LO && rx_valid) len_lo_q <= rx_data;
            if (state_q == ST_LEN_HI && rx_valid) len_q    <= len_word;
            if (wr_fire) wr_data_q <= word_d;

            if (sync_entry) begin
                addr_q     <= '0;
                word_cnt_q <= '0;
                byte_idx_q <= '0;
                word_q     <= '0;
`ifdef UART_BOOT_CHECKSUM_EN
                csum_q     <= '0;
`endif
            end else begin
                // Address advances at the end of the write cycle so it equals the word index during the strobe.
                if (wr_en_q) addr_q <= addr_q + 1'b1;
                if (state_q == ST_DATA && rx_valid) begin
                    word_q     <= word_d;
                    byte_idx_q <= last_byte ? '0 : byte_idx_q + 1'b1;
                    if (last_byte) word_cnt_q <= word_cnt_q + 16'd1;
`ifdef UART_BOOT_CHECKSUM_EN
                    csum_q     <= csum_q ^ rx_data;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// tb/tb_uart_boot_ctrl.sv - directed self-checking bench for uart_boot_ctrl
module tb_uart_boot_ctrl;
    localparam int ADDR_LEN = 14;
    localparam int XLEN     = 32;
    localparam int TCYC     = 40;

    logic clk = 1'b0;
    logic rstb;
    always #5 clk = ~clk;

    uart_boot_ctrl_if #(.ADDR_LEN(ADDR_LEN), .XLEN(XLEN)) bus ();

    uart_boot_ctrl #(.ADDR_LEN(ADDR_LEN), .XLEN(XLEN), .TIMEOUT_CYC(TCYC)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_LEN-1:0] wa[$];
    logic [XLEN-1:0]     wd[$];
    logic [XLEN/8-1:0]   wwe[$];

    always @(negedge clk) begin
        if (bus.ram_wr_en === 1'b1) begin
            wa.push_back(bus.ram_addr);
            wd.push_back(bus.ram_wr_data);
            wwe.push_back(bus.ram_we);
        end
    end

    task automatic clear_log();
        wa.delete(); wd.delete(); wwe.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_wr);
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = b;
        @(negedge clk);
        bus.uart_rx_valid = 1'b0;
        n_checks++;
        if (bus.ram_wr_en !== exp_wr) begin n_fail++; $display("FAIL wr_strobe byte %h: got %b expected %b", b, bus.ram_wr_en, exp_wr); end
    endtask

    task automatic start_boot();
        bus.boot_req_b = 1'b0;
        @(negedge clk);
        bus.boot_req_b = 1'b1;
        n_checks++;
        if (bus.boot_busy !== 1'b1) begin n_fail++; $display("FAIL sync_busy: got %b expected 1", bus.boot_busy); end
        n_checks++;
        if (bus.boot_err !== 2'd0) begin n_fail++; $display("FAIL sync_err_clear: got %0d expected 0", bus.boot_err); end
        n_checks++;
        if (bus.ram_addr !== '0) begin n_fail++; $display("FAIL sync_addr_clear: got %0d expected 0", bus.ram_addr); end
        clear_log();
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        bus.boot_req_b = 1'b1;
        bus.uart_rx_valid = 1'b0;
        bus.uart_rx_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_hold: got %b expected 1", bus.cpu_hold); end
        n_checks++; if (bus.boot_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus.boot_busy); end
        n_checks++; if (bus.boot_err !== 2'd0) begin n_fail++; $display("FAIL rst_err: got %0d expected 0", bus.boot_err); end
        n_checks++; if (bus.ram_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b expected 0", bus.ram_wr_en); end
        n_checks++; if (bus.ram_addr !== '0) begin n_fail++; $display("FAIL rst_addr: got %0d expected 0", bus.ram_addr); end
        n_checks++; if (bus.ram_wr_data !== '0) begin n_fail++; $display("FAIL rst_wr_data: got %h expected 0", bus.ram_wr_data); end
        n_checks++; if (bus.ram_we !== '0) begin n_fail++; $display("FAIL rst_we: got %h expected 0", bus.ram_we); end
        rstb = 1'b1;
        clear_log();
        @(negedge clk);
        n_checks++; if (bus.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL nb_cpu_hold: got %b expected 0", bus.cpu_hold); end
        n_checks++; if (bus.boot_busy !== 1'b0) begin n_fail++; $display("FAIL nb_busy: got %b expected 0", bus.boot_busy); end
        @(negedge clk);
        n_checks++; if (wa.size() != 0) begin n_fail++; $display("FAIL nb_writes: got %0d expected 0", wa.size()); end
    endtask

    task automatic test_boot_ok();
        logic [7:0] f [9] = '{8'h00, 8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        start_boot();
        for (int i = 0; i < 9; i++) send_byte(f[i], i == 7);
        @(negedge clk); @(negedge clk);
        n_checks++; if (bus.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL ok_cpu_hold: got %b expected 0", bus.cpu_hold); end
        n_checks++; if (bus.boot_err !== 2'd0) begin n_fail++; $display("FAIL ok_err: got %0d expected 0", bus.boot_err); end
        n_checks++; if (bus.boot_busy !== 1'b0) begin n_fail++; $display("FAIL ok_busy: got %b expected 0", bus.boot_busy); end
        n_checks++; if (bus.ram_addr !== 14'd1) begin n_fail++; $display("FAIL ok_addr_inc: got %0d expected 1", bus.ram_addr); end
        n_checks++;
        if (wa.size() != 1) begin n_fail++; $display("FAIL ok_write_count: got %0d expected 1", wa.size()); end
        else if (wa[0] !== 14'd0 || wd[0] !== 32'h44332211 || wwe[0] !== 4'hF) begin
            n_fail++; $display("FAIL ok_write: got addr %0d data %h we %h expected addr 0 data 44332211 we f", wa[0], wd[0], wwe[0]);
        end
    endtask

    task automatic test_csum_err();
        logic [7:0] f [8] = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        start_boot();
        for (int i = 0; i < 8; i++) send_byte(f[i], i == 6);
        @(negedge clk);
`ifdef UART_BOOT_CHECKSUM_EN
        n_checks++; if (bus.boot_err !== 2'd3) begin n_fail++; $display("FAIL csum_err: got %0d expected 3", bus.boot_err); end
        n_checks++; if (bus.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL csum_cpu_hold: got %b expected 1", bus.cpu_hold); end
`else
        n_checks++; if (bus.boot_err !== 2'd0) begin n_fail++; $display("FAIL csum_err: got %0d expected 0", bus.boot_err); end
        n_checks++; if (bus.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL csum_cpu_hold: got %b expected 0", bus.cpu_hold); end
`endif
        n_checks++; if (wa.size() != 1) begin n_fail++; $display("FAIL csum_write_count: got %0d expected 1", wa.size()); end
    endtask

    task automatic test_len_err();
        logic [7:0] f [3] = '{8'hA5, 8'h01, 8'h80};
        start_boot();
        for (int i = 0; i < 3; i++) send_byte(f[i], 1'b0);
        n_checks++; if (bus.boot_err !== 2'd2) begin n_fail++; $display("FAIL len_err: got %0d expected 2", bus.boot_err); end
        n_checks++; if (bus.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL len_cpu_hold: got %b expected 1", bus.cpu_hold); end
        n_checks++; if (bus.boot_busy !== 1'b0) begin n_fail++; $display("FAIL len_busy: got %b expected 0", bus.boot_busy); end
        @(negedge clk); @(negedge clk);
        n_checks++; if (wa.size() != 0) begin n_fail++; $display("FAIL len_writes: got %0d expected 0", wa.size()); end
    endtask

    task automatic test_timeout();
        logic [7:0] f [8] = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        start_boot();
        for (int i = 0; i < 8; i++) send_byte(f[i], i == 6);
        repeat (TCYC - 1) @(negedge clk);
        n_checks++; if (bus.boot_err !== 2'd0 || bus.boot_busy !== 1'b1) begin n_fail++; $display("FAIL to_early: got err %0d busy %b expected err 0 busy 1", bus.boot_err, bus.boot_busy); end
        @(negedge clk);
        n_checks++; if (bus.boot_err !== 2'd1) begin n_fail++; $display("FAIL to_err: got %0d expected 1", bus.boot_err); end
        n_checks++; if (bus.cpu_hold !== 1'b1 || bus.boot_busy !== 1'b0) begin n_fail++; $display("FAIL to_state: got hold %b busy %b expected hold 1 busy 0", bus.cpu_hold, bus.boot_busy); end
        n_checks++;
        if (wa.size() != 1) begin n_fail++; $display("FAIL to_write_count: got %0d expected 1", wa.size()); end
        else if (wa[0] !== 14'd0 || wd[0] !== 32'h04030201) begin
            n_fail++; $display("FAIL to_write: got addr %0d data %h expected addr 0 data 04030201", wa[0], wd[0]);
        end
    endtask

    task automatic test_timeout_priority();
        logic [7:0] f [7] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h40, 8'h00};
        start_boot();
        send_byte(8'hA5, 1'b0);
        repeat (TCYC - 1) @(negedge clk);
        send_byte(8'h01, 1'b0);
        n_checks++; if (bus.boot_err !== 2'd0 || bus.boot_busy !== 1'b1) begin n_fail++; $display("FAIL prio_expiry: got err %0d busy %b expected err 0 busy 1", bus.boot_err, bus.boot_busy); end
        for (int i = 0; i < 6; i++) send_byte(f[i], i == 4);
        @(negedge clk);
        n_checks++; if (bus.cpu_hold !== 1'b0 || bus.boot_err !== 2'd0) begin n_fail++; $display("FAIL prio_done: got hold %b err %0d expected hold 0 err 0", bus.cpu_hold, bus.boot_err); end
        n_checks++;
        if (wa.size() != 1) begin n_fail++; $display("FAIL prio_write_count: got %0d expected 1", wa.size()); end
        else if (wd[0] !== 32'h40302010) begin n_fail++; $display("FAIL prio_write: got %h expected 40302010", wd[0]); end
    endtask

    task automatic test_back_to_back_reset();
        logic [7:0] f [13] = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                                8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        logic [7:0] g [8]  = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        start_boot();
        for (int i = 0; i < 13; i++) send_byte(f[i], i == 6 || i == 10);
        n_checks++; if (wa.size() != 2) begin n_fail++; $display("FAIL mid_pre_writes: got %0d expected 2", wa.size()); end
        rstb = 1'b0;
        bus.boot_req_b = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.cpu_hold !== 1'b1 || bus.boot_busy !== 1'b0 || bus.boot_err !== 2'd0) begin n_fail++; $display("FAIL mid_rst_status: got hold %b busy %b err %0d expected 1 0 0", bus.cpu_hold, bus.boot_busy, bus.boot_err); end
        n_checks++; if (bus.ram_wr_en !== 1'b0 || bus.ram_addr !== '0 || bus.ram_wr_data !== '0 || bus.ram_we !== '0) begin n_fail++; $display("FAIL mid_rst_ram: got en %b addr %0d data %h we %h expected all 0", bus.ram_wr_en, bus.ram_addr, bus.ram_wr_data, bus.ram_we); end
        rstb = 1'b1;
        @(negedge clk);
        bus.boot_req_b = 1'b1;
        n_checks++; if (bus.boot_busy !== 1'b1) begin n_fail++; $display("FAIL mid_resync: got busy %b expected 1", bus.boot_busy); end
        n_checks++; if (wa.size() != 2) begin n_fail++; $display("FAIL mid_post_writes: got %0d expected 2", wa.size()); end
        clear_log();
        for (int i = 0; i < 8; i++) send_byte(g[i], i == 6);
        @(negedge clk);
        n_checks++; if (bus.cpu_hold !== 1'b0 || bus.boot_err !== 2'd0) begin n_fail++; $display("FAIL mid_done: got hold %b err %0d expected hold 0 err 0", bus.cpu_hold, bus.boot_err); end
        n_checks++;
        if (wa.size() != 1) begin n_fail++; $display("FAIL mid_write_count: got %0d expected 1", wa.size()); end
        else if (wa[0] !== 14'd0 || wd[0] !== 32'hDDCCBBAA) begin
            n_fail++; $display("FAIL mid_write: got addr %0d data %h expected addr 0 data ddccbbaa", wa[0], wd[0]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rstb = 1'b0;
        bus.boot_req_b = 1'b1;
        bus.uart_rx_valid = 1'b0;
        bus.uart_rx_data = 8'h00;
        @(negedge clk);
        test_reset();
        test_boot_ok();
        test_csum_err();
        test_len_err();
        test_timeout();
        test_timeout_priority();
        test_back_to_back_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
